// File: rtl/alu8_issue.sv
// alu8_issue: command FIFO and issue stage feeding a combinational alu8, with a registered result port.
// Optional macro ALU8_ISSUE_ACC_EN adds an accumulator so a command can take the previous result as A.
module alu8_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_sel,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    input  logic                     cmd_acc,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic [2:0]               alu_sel,
    input  logic [7:0]               alu_y,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [2:0]               res_sel,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_a   [DEPTH];
    logic [7:0]    r_b   [DEPTH];
    logic [2:0]    r_sel [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          r_res_valid;
    logic [7:0]    r_res_data;
    logic [2:0]    r_res_sel;
    logic          w_push, w_issue, w_nonempty;
    logic [7:0]    w_head_a;

    assign w_nonempty = !rst && r_count != '0;
    assign cmd_ready  = !rst && r_count < CW'(DEPTH);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_issue    = w_nonempty && (!r_res_valid || res_ready);

`ifdef ALU8_ISSUE_ACC_EN
    logic       r_accf [DEPTH];
    logic [7:0] r_acc;
    assign w_head_a = r_accf[r_rp] ? r_acc : r_a[r_rp];
    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (w_issue)
            r_acc <= alu_y;
        if (w_push)
            r_accf[r_wp] <= cmd_acc;
    end
`else
    logic w_unused;
    assign w_unused = cmd_acc;
    assign w_head_a = r_a[r_rp];
`endif

    assign alu_a     = w_nonempty ? w_head_a : '0;
    assign alu_b     = w_nonempty ? r_b[r_rp] : '0;
    assign alu_sel   = w_nonempty ? r_sel[r_rp] : '0;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_sel   = r_res_sel;
    assign count     = r_count;
    assign busy      = !rst && (r_count != '0 || r_res_valid);

    // Storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_a[r_wp]   <= cmd_a;
            r_b[r_wp]   <= cmd_b;
            r_sel[r_wp] <= cmd_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_issue);
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_issue) begin
                r_rp        <= r_rp + 1'b1;
                r_res_data  <= alu_y;
                r_res_sel   <= r_sel[r_rp];
                r_res_valid <= 1'b1;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end
endmodule
